step_phase_mon: RTL

//   Receive-side monitor/decoder for the four-phase one-hot step strobes (step1..step4).

---
 rtl/step_phase_mon.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/step_phase_mon.sv
// Receive-side monitor for the four-phase one-hot step strobes. It acquires lock on a clean
// 1->2->3->4 rotation, then drives per-stage enables and tracks rounds and protocol errors.
module step_phase_mon #(
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step1,
  input  logic             step2,
  input  logic             step3,
  input  logic             step4,
  input  logic             err_clr,
  output logic             locked,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic [1:0]       phase,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] round_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t             r_state;
  logic [GOOD_W-1:0]  r_good;
  logic               r_locked;
  logic [3:0]         r_en;
  logic [1:0]         r_phase;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_round_cnt;

  logic [3:0]         w_steps;
  logic               w_valid;
  logic [1:0]         w_idx;
  logic [1:0]         w_exp;
  logic               w_in_order;
  logic               w_err_evt;

  assign w_steps = {step4, step3, step2, step1};
  assign w_valid = (w_steps != 4'd0) && ((w_steps & (w_steps - 4'd1)) == 4'd0);
  assign w_exp   = r_phase + 2'd1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_idx = 2'd0;
    case (w_steps)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_in_order = w_valid && (w_idx == w_exp);
  // Anything short of the next in-order phase while locked is a protocol violation.
  assign w_err_evt  = (r_state == LOCK) && !w_in_order;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_good       <= '0;
      r_locked     <= 1'b0;
      r_en         <= 4'd0;
      r_phase      <= 2'd0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_round_cnt  <= '0;
    end else begin
      r_en <= 4'd0;
      if (w_valid) r_phase <= w_idx;

      case (r_state)
        HUNT: begin
          if (w_valid) begin
            r_state <= ACQ;
            r_good  <= GOOD_W'(1);
          end
        end
        ACQ: begin
          if (w_in_order) begin
            r_good <= r_good + GOOD_W'(1);
            if (r_good == GOOD_W'(LOCK_CYCLES - 1)) begin
              r_state  <= LOCK;
              r_locked <= 1'b1;
            end
          end else begin
            r_state <= HUNT;
            r_good  <= '0;
          end
        end
        LOCK: begin
          if (w_in_order) begin
            r_en <= 4'd1 << w_idx;
            if (w_idx == 2'd3) r_round_cnt <= r_round_cnt + CNT_W'(1);
          end else begin
            r_state  <= HUNT;
            r_good   <= '0;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= HUNT;
          r_good   <= '0;
          r_locked <= 1'b0;
        end
      endcase

      // A violation coinciding with err_clr is counted on top of the clear.
      if (w_err_evt) begin
        r_err_sticky <= 1'b1;
        if (err_clr)              r_err_cnt <= CNT_W'(1);
        else if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end
    end
  end

  assign locked     = r_locked;
  assign fetch_en   = r_en[0];
  assign decode_en  = r_en[1];
  assign exec_en    = r_en[2];
  assign wb_en      = r_en[3];
  assign phase      = r_phase;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign round_cnt  = r_round_cnt;

endmodule
